// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes.
//
// Stage S1 registers the operands and opcode. Stage S2 registers the result,
// the compare marker (set_flags) and the compare outcome. Both stages stall
// independently, so a full pipeline sustains one beat per cycle. Beats with
// an unknown opcode still flow through with a zero result and are counted.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand beat present
//   in_ready     block accepts a beat this cycle (combinational from out_ready)
//   in1, in2     signed operands, WIDTH bits
//   opcode       5-bit operation select
//   out_valid    result beat present
//   out_ready    consumer accepts the result this cycle
//   out          result, WIDTH bits
//   set_flags    result beat is a compare (qualified by out_valid)
//   flags        {lt, eq, gt} of the most recently consumed compare
//   illegal_cnt  saturating count of accepted illegal-opcode beats
//
// Parameters: WIDTH (even, >= 8), CNT_W (illegal counter width).
// Build option: define ALU_PIPE_SAT_EN to make ADD/ADDR/SUB/SUBR clamp to the
// signed range on overflow instead of wrapping.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             set_flags,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] SHAMT_LIM = WIDTH'(WIDTH);

  typedef enum logic [4:0] {
    OP_LL   = 5'b01010,
    OP_LH   = 5'b01011,
    OP_CMP  = 5'b00110,
    OP_CMPR = 5'b00111,
    OP_ADD  = 5'b10000,
    OP_ADDR = 5'b10001,
    OP_SUB  = 5'b10010,
    OP_SUBR = 5'b10011,
    OP_SHL  = 5'b10100,
    OP_SHR  = 5'b10101,
    OP_AND  = 5'b10110,
    OP_NOT  = 5'b10111,
    OP_OR   = 5'b11000,
    OP_XOR  = 5'b11001
  } op_e;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_LL, OP_LH, OP_CMP, OP_CMPR, OP_ADD, OP_ADDR, OP_SUB, OP_SUBR,
      OP_SHL, OP_SHR, OP_AND, OP_NOT, OP_OR, OP_XOR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  // Pipeline state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_in1;
  logic [WIDTH-1:0] s1_in2;
  logic [4:0]       s1_op;
  logic [2:0]       s2_cmp;

  // A stage may load when it is empty or its content leaves this cycle.
  logic adv1;
  logic adv2;

  assign adv2      = !out_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;

  // Arithmetic results, wrapping or clamping depending on the build.
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;

`ifdef ALU_PIPE_SAT_EN
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;

  // One guard bit of sign extension: overflow shows up as the two top bits
  // disagreeing, and the guard bit tells which direction it went.
  function automatic logic [WIDTH-1:0] sat_fix(input logic [WIDTH:0] ext);
    if (ext[WIDTH] != ext[WIDTH-1])
      return ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return ext[WIDTH-1:0];
  endfunction

  assign add_ext = {s1_in1[WIDTH-1], s1_in1} + {s1_in2[WIDTH-1], s1_in2};
  assign sub_ext = {s1_in1[WIDTH-1], s1_in1} - {s1_in2[WIDTH-1], s1_in2};
  assign add_res = sat_fix(add_ext);
  assign sub_res = sat_fix(sub_ext);
`else
  assign add_res = s1_in1 + s1_in2;
  assign sub_res = s1_in1 - s1_in2;
`endif

  // The arithmetic shift is kept in its own assignment so the signed operand
  // is not turned unsigned by a surrounding conditional expression.
  logic [WIDTH-1:0] shr_raw;
  logic             shamt_big;

  assign shr_raw   = $signed(s1_in1) >>> s1_in2;
  assign shamt_big = (s1_in2 >= SHAMT_LIM);

  logic [WIDTH-1:0] alu_res;
  logic             alu_sf;
  logic [2:0]       alu_cmp;

  always_comb begin
    // NOTE: every output gets a default first, so no opcode path can infer a latch.
    alu_res = '0;
    alu_sf  = 1'b0;
    alu_cmp = 3'b000;
    case (s1_op)
      OP_LL:           alu_res = {s1_in1[WIDTH-1:HALF], s1_in2[HALF-1:0]};
      OP_LH:           alu_res = {s1_in2[WIDTH-1:HALF], s1_in1[HALF-1:0]};
      OP_CMP, OP_CMPR: begin
        alu_sf  = 1'b1;
        alu_cmp = {$signed(s1_in1) <  $signed(s1_in2),
                   s1_in1 == s1_in2,
                   $signed(s1_in1) >  $signed(s1_in2)};
      end
      OP_ADD, OP_ADDR: alu_res = add_res;
      OP_SUB, OP_SUBR: alu_res = sub_res;
      OP_SHL:          alu_res = shamt_big ? '0 : (s1_in1 << s1_in2);
      OP_SHR:          alu_res = shamt_big ? {WIDTH{s1_in1[WIDTH-1]}} : shr_raw;
      OP_AND:          alu_res = s1_in1 & s1_in2;
      OP_NOT:          alu_res = ~s1_in1;
      OP_OR:           alu_res = s1_in1 | s1_in2;
      OP_XOR:          alu_res = s1_in1 ^ s1_in2;
      default:         alu_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well, because out must read 0 and
      // flags/illegal_cnt must clear while rst_n is low.
      s1_valid    <= 1'b0;
      s1_in1      <= '0;
      s1_in2      <= '0;
      s1_op       <= '0;
      out_valid   <= 1'b0;
      out         <= '0;
      set_flags   <= 1'b0;
      s2_cmp      <= 3'b000;
      flags       <= 3'b000;
      illegal_cnt <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_in1 <= in1;
          s1_in2 <= in2;
          s1_op  <= opcode;
        end
      end

      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out       <= alu_res;
          set_flags <= alu_sf;
          s2_cmp    <= alu_cmp;
        end
      end

      // Flags follow consumed compares only, not merely produced ones.
      if (out_valid && out_ready && set_flags)
        flags <= s2_cmp;

      if (in_valid && adv1 && !op_legal(opcode) && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=16, CNT_W=8).
// Expected results are pushed to a queue as beats are accepted and popped by a
// monitor as the DUT delivers them. The monitor also tracks the expected flag
// register and checks that stalled outputs hold still.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 16;

  localparam logic [4:0] OP_LL   = 5'b01010;
  localparam logic [4:0] OP_LH   = 5'b01011;
  localparam logic [4:0] OP_CMP  = 5'b00110;
  localparam logic [4:0] OP_CMPR = 5'b00111;
  localparam logic [4:0] OP_ADD  = 5'b10000;
  localparam logic [4:0] OP_ADDR = 5'b10001;
  localparam logic [4:0] OP_SUB  = 5'b10010;
  localparam logic [4:0] OP_SUBR = 5'b10011;
  localparam logic [4:0] OP_SHL  = 5'b10100;
  localparam logic [4:0] OP_SHR  = 5'b10101;
  localparam logic [4:0] OP_AND  = 5'b10110;
  localparam logic [4:0] OP_NOT  = 5'b10111;
  localparam logic [4:0] OP_OR   = 5'b11000;
  localparam logic [4:0] OP_XOR  = 5'b11001;

  logic [4:0] legal_ops [14] = '{OP_LL, OP_LH, OP_CMP, OP_CMPR, OP_ADD, OP_ADDR,
                                 OP_SUB, OP_SUBR, OP_SHL, OP_SHR, OP_AND, OP_NOT,
                                 OP_OR, OP_XOR};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [4:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         set_flags;
  logic [2:0]   flags;
  logic [7:0]   illegal_cnt;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .set_flags   (set_flags),
    .flags       (flags),
    .illegal_cnt (illegal_cnt)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         sf;
    logic [2:0]   cmp;
  } exp_t;

  exp_t         q[$];
  exp_t         popped;
  int           checks = 0;
  int           failures = 0;
  int           n_popped = 0;
  int           exp_ill = 0;
  logic [2:0]   exp_flags = 3'b000;
  logic [W-1:0] last_out = '0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out = '0;
  logic         prev_sf = 1'b0;
  logic         stream_done = 1'b0;

  function automatic logic is_legal(input logic [4:0] op);
    foreach (legal_ops[i])
      if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model written from the operation definitions.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int sa, sb, r;
    logic signed [W-1:0] a_s;
    logic [W-1:0] sh;
    e = '0;
    a_s = a;
    sa = a_s;
    a_s = b;
    sb = a_s;
    a_s = a;
    case (op)
      OP_LL: e.res = {a[15:8], b[7:0]};
      OP_LH: e.res = {b[15:8], a[7:0]};
      OP_CMP, OP_CMPR: begin
        e.sf  = 1'b1;
        e.cmp = {sa < sb, sa == sb, sa > sb};
      end
      OP_ADD, OP_ADDR, OP_SUB, OP_SUBR: begin
        r = (op == OP_ADD || op == OP_ADDR) ? sa + sb : sa - sb;
`ifdef ALU_PIPE_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        e.res = r[15:0];
      end
      OP_SHL: begin
        if (b >= 16) e.res = '0;
        else         e.res = a << b[3:0];
      end
      OP_SHR: begin
        sh = a_s >>> b[3:0];
        if (b >= 16) e.res = {16{a[15]}};
        else         e.res = sh;
      end
      OP_AND: e.res = a & b;
      OP_NOT: e.res = ~a;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      default: e.res = '0;
    endcase
    return e;
  endfunction

  // Monitor: scoreboard pop, flag tracking, stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (flags !== exp_flags) begin
        failures++;
        $display("FAIL flags_track: got %b expected %b at %0t", flags, exp_flags, $time);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out !== prev_out || set_flags !== prev_sf) begin
          failures++;
          $display("FAIL stall_hold: got v=%b out=%h sf=%b expected v=1 out=%h sf=%b",
                   out_valid, out, set_flags, prev_out, prev_sf);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got out=%h expected no beat", out);
        end else begin
          popped = q.pop_front();
          n_popped++;
          last_out = out;
          if (out !== popped.res || set_flags !== popped.sf) begin
            failures++;
            $display("FAIL result: got out=%h sf=%b expected out=%h sf=%b",
                     out, set_flags, popped.res, popped.sf);
          end
          if (popped.sf) exp_flags = popped.cmp;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      prev_sf    = set_flags;
    end
  end

  task automatic send_beat(input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, output int waited);
    in1 = a;
    in2 = b;
    opcode = op;
    in_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waited++;
      if (waited >= 200) break;
    end
    checks++;
    if (in_ready === 1'b1) begin
      q.push_back(model(op, a, b));
      if (!is_legal(op) && exp_ill < 255) exp_ill++;
    end else begin
      failures++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1 within 200 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int w;
    send_beat(op, a, b, w);
    drain();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    q.delete();
    exp_flags = 3'b000;
    exp_ill = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out !== 16'h0000 || set_flags !== 1'b0 ||
        flags !== 3'b000 || illegal_cnt !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got v=%b out=%h sf=%b flags=%b cnt=%h rdy=%b expected 0/0000/0/000/00/1",
               out_valid, out, set_flags, flags, illegal_cnt, in_ready);
    end
    do_reset();
  endtask

  task automatic test_add_latency();
    int w;
    out_ready = 1'b1;
    send_beat(OP_ADD, 16'hAAAA, 16'h5555, w);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: got out_valid=%b expected 0 one cycle after accept", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out !== 16'hFFFF || set_flags !== 1'b0) begin
      failures++;
      $display("FAIL add_latency: got v=%b out=%h sf=%b expected 1/FFFF/0", out_valid, out, set_flags);
    end
    drain();
  endtask

  task automatic test_shift();
    run_one(OP_SHR, 16'h8000, 16'h000F);
    checks++;
    if (last_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL shr_15: got %h expected FFFF", last_out);
    end
    run_one(OP_SHR, 16'h8000, 16'h0020);
    checks++;
    if (last_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL shr_big: got %h expected FFFF", last_out);
    end
    run_one(OP_SHL, 16'h0001, 16'h0010);
    checks++;
    if (last_out !== 16'h0000) begin
      failures++;
      $display("FAIL shl_16: got %h expected 0000", last_out);
    end
    run_one(OP_LL, 16'h1234, 16'hABCD);
    checks++;
    if (last_out !== 16'h12CD) begin
      failures++;
      $display("FAIL ll: got %h expected 12CD", last_out);
    end
    run_one(OP_LH, 16'h1234, 16'hABCD);
    checks++;
    if (last_out !== 16'hAB34) begin
      failures++;
      $display("FAIL lh: got %h expected AB34", last_out);
    end
  endtask

  task automatic test_flags();
    run_one(OP_CMP, 16'hFFFE, 16'h0003);
    checks++;
    if (flags !== 3'b100) begin
      failures++;
      $display("FAIL cmp_lt: got %b expected 100", flags);
    end
    run_one(OP_ADD, 16'h0001, 16'h0002);
    checks++;
    if (flags !== 3'b100) begin
      failures++;
      $display("FAIL flags_hold: got %b expected 100", flags);
    end
    run_one(OP_CMPR, 16'h0005, 16'h0005);
    checks++;
    if (flags !== 3'b010) begin
      failures++;
      $display("FAIL cmp_eq: got %b expected 010", flags);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_add, exp_sub;
`ifdef ALU_PIPE_SAT_EN
    exp_add = 16'h7FFF;
    exp_sub = 16'h8000;
`else
    exp_add = 16'h8000;
    exp_sub = 16'h7FFF;
`endif
    run_one(OP_ADD, 16'h7FFF, 16'h0001);
    checks++;
    if (last_out !== exp_add) begin
      failures++;
      $display("FAIL add_ovf: got %h expected %h", last_out, exp_add);
    end
    run_one(OP_SUB, 16'h8000, 16'h0001);
    checks++;
    if (last_out !== exp_sub) begin
      failures++;
      $display("FAIL sub_ovf: got %h expected %h", last_out, exp_sub);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_beat(legal_ops[$urandom_range(0, 13)], 16'($urandom), 16'($urandom_range(0, 20)), w);
      checks++;
      if (w != 0) begin
        failures++;
        $display("FAIL back_to_back: got %0d wait cycles expected 0", w);
      end
    end
    drain();
  endtask

  task automatic test_stall();
    int w;
    out_ready = 1'b0;
    send_beat(OP_XOR, 16'h0F0F, 16'h00FF, w);
    send_beat(OP_NOT, 16'h1234, 16'hFFFF, w);
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_ready: got in_ready=%b expected 0 with both stages full", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_stream();
    int start = n_popped;
    stream_done = 1'b0;
    fork
      begin
        int w;
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_beat(legal_ops[$urandom_range(0, 13)], 16'($urandom),
                    ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom), w);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    checks++;
    if (n_popped - start != 10) begin
      failures++;
      $display("FAIL stream_count: got %0d beats expected 10", n_popped - start);
    end
  endtask

  task automatic test_illegal();
    int w;
    do_reset();
    for (int i = 0; i < 300; i++)
      send_beat(5'b00000, 16'($urandom), 16'($urandom), w);
    drain();
    checks++;
    if (illegal_cnt !== 8'(exp_ill) || illegal_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL illegal_sat: got %h expected FF", illegal_cnt);
    end
    for (int i = 0; i < 4; i++)
      send_beat(5'b11111, 16'h5A5A, 16'hA5A5, w);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || illegal_cnt !== 8'h00 || flags !== 3'b000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got v=%b cnt=%h flags=%b rdy=%b expected 0/00/000/1",
               out_valid, illegal_cnt, flags, in_ready);
    end
    q.delete();
    exp_flags = 3'b000;
    exp_ill = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one(OP_ADD, 16'h0001, 16'h0002);
    checks++;
    if (last_out !== 16'h0003) begin
      failures++;
      $display("FAIL post_reset_add: got %h expected 0003", last_out);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_shift();
    test_flags();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_stream();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter CNT_W, default 8, width of the illegal-opcode counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in1, in2  input  WIDTH each  signed operands.
REQ-008 opcode  input  5  operation select, encodings per REQ-014.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 set_flags  output  1  result beat is a compare; qualified by out_valid.
REQ-013 flags  output  3  registered compare flags; illegal_cnt  output  CNT_W  illegal-opcode count.

Function
REQ-014 Opcodes SHALL be LL=01010, LH=01011, CMP=00110, CMPR=00111, ADD=10000, ADDR=10001, SUB=10010, SUBR=10011, SHL=10100, SHR=10101, AND=10110, NOT=10111, OR=11000, XOR=11001; every other code is illegal.
REQ-015 LL: out={in1[W-1:W/2], in2[W/2-1:0]}; LH: out={in2[W-1:W/2], in1[W/2-1:0]}.
REQ-016 ADD/ADDR: in1+in2; SUB/SUBR: in1-in2, modulo 2^WIDTH (see REQ-030).
REQ-017 SHL: in1 logical left shift by unsigned in2; an amount >= WIDTH gives 0.
REQ-018 SHR: in1 arithmetic right shift by unsigned in2; an amount >= WIDTH gives all bits equal to in1[W-1].
REQ-019 AND/OR/XOR are bitwise; NOT: out=~in1, in2 ignored.
REQ-020 CMP/CMPR: out=0, set_flags=1, signed compare producing {in1<in2, in1==in2, in1>in2}.
REQ-021 Illegal opcode: out=0, set_flags=0, the beat still flows through the pipeline.
REQ-022 Two register stages: S1 holds operands and opcode; S2 holds out, set_flags and the compare result.
REQ-023 Stage advance: adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational path from out_ready is permitted).
REQ-024 A beat is accepted when in_valid && in_ready; with out_ready held high, out_valid rises exactly 2 cycles after acceptance, at a throughput of one beat per cycle.
REQ-025 While out_valid && !out_ready, out, set_flags and out_valid SHALL hold stable; no beat is lost or duplicated under any pattern of in_valid/out_ready.
REQ-026 flags SHALL load the compare result only when a set_flags beat is consumed (out_valid && out_ready && set_flags), and otherwise hold its value.
REQ-027 illegal_cnt SHALL increment by 1 when an illegal beat is accepted, and saturate at all-ones.
REQ-028 Accept and consume in the same cycle SHALL both take effect.

Reset
REQ-029 While rst_n=0: s1_valid=0, s2_valid=0, out_valid=0, out=0, set_flags=0, flags=000, illegal_cnt=0, in_ready=1 after reset; asserting reset mid-operation SHALL discard in-flight beats and leave flags and illegal_cnt cleared.

Configuration
REQ-030 Macro ALU_PIPE_SAT_EN: when defined, ADD/ADDR/SUB/SUBR results that overflow signed range SHALL clamp to 0111..1 (positive overflow) or 1000..0 (negative overflow); when undefined they wrap modulo 2^WIDTH; all other ops are unaffected.

Verification
REQ-031 ADD with in1=AAAA, in2=5555, out_ready=1 -> out=FFFF, out_valid 2 cycles after accept, set_flags=0.
REQ-032 SHR with in1=8000, in2=000F -> FFFF; SHR with in2=0020 -> FFFF; SHL with in1=0001, in2=0010 -> 0000.
REQ-033 CMP with in1=FFFE, in2=0003 consumed -> flags=100; a following ADD beat leaves flags=100; CMP with 0005/0005 -> flags=010.
REQ-034 ADD with in1=7FFF, in2=0001 -> 8000 without ALU_PIPE_SAT_EN, 7FFF with it; SUB with 8000-0001 -> 7FFF / 8000 respectively.
REQ-035 Stream 10 random beats with out_ready toggling on a pseudo-random pattern -> outputs match the model in order, with no loss or duplication, and out is stable while stalled.
REQ-036 Send opcode 00000 for 300 beats with CNT_W=8 -> out=0 on each, illegal_cnt=FF; pulse rst_n low mid-stream -> out_valid=0 and illegal_cnt=0 immediately.
